seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Parametrised, time-multiplexed 7-segment display driver for the microwave front panel. It generalises the fixed three-digit BCD decoder to NUM_DIGITS digits. Digits are scanned one at a time over shared segment lines, with frame-synchronous value update, leading-zero blanking, per-digit blink and invalid-code indication. It sits between the timer/counter logic and the physical display pins.

## Interface
Parameters:
- NUM_DIGITS, 3: number of digits; digit 0 is least significant (second units).
- SCAN_DIV, 1000: clock cycles each digit stays active; ≥2.
- BLINK_FRAMES, 64: full scan frames per blink half-period; ≥1.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the pins.
- DIG_ACTIVE_LOW, 0: 1 inverts dig_sel at the pins.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- digits_bcd, input, 4*NUM_DIGITS: BCD nibbles; digit i is bits [4i+3:4i].
- load, input, 1: capture strobe for digits_bcd.
- blank_lz, input, 1: enable leading-zero blanking.
- blink_en, input, NUM_DIGITS: per-digit blink enable.
- dp_en, input, NUM_DIGITS: per-digit decimal point.
- seg, output, 7: {g,f,e,d,c,b,a}, registered.
- dp, output, 1: decimal point, registered.
- dig_sel, output, NUM_DIGITS: one-hot digit enable, registered.
- frame_done, output, 1: one-cycle pulse at each frame wrap.

## Operation
- Prescaler counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index advances.
- Index wraps from NUM_DIGITS-1 to 0. That wrap is the frame boundary.
- load=1 captures digits_bcd into the pending register.
- At each frame boundary the shadow register takes the pending value.
  - If load is asserted in the boundary cycle, shadow takes digits_bcd directly.
  - Scanned values never tear mid-frame.
- The frame counter counts boundaries 0..BLINK_FRAMES-1. On wrap, blink_phase toggles.
- Decode of the shadow nibble (logical, before polarity):
  - 0–9: standard patterns. 0 is 0111111, 1 is 0000110, 8 is 1111111.
  - 10–15: dash, 1000000.
- Blanking: the digit shows 0000000 and dp=0 when either condition holds:
  - blink_en[i]=1 and blink_phase=1.
  - blank_lz=1, digit i>0, and digits NUM_DIGITS-1..i of shadow are all zero. Digit 0 is never blanked by this rule.
- dp = dp_en[idx] unless the digit is blanked.
- dig_sel has exactly one bit active at all times after the first post-reset cycle.
- Reset values:
  - prescaler, index, frame counter, blink_phase: 0.
  - pending and shadow: all zeros.
  - seg and dp: logical off.
  - dig_sel: all inactive.
  - frame_done: 0.
- Reset asserted mid-frame returns everything to the reset state immediately. Pending data is lost.

## Timing
- Outputs are registered. They reflect the index/shadow state of the previous cycle, so latency from index change to pins is 1 cycle.
- Each digit is active for exactly SCAN_DIV consecutive cycles. One frame is NUM_DIGITS*SCAN_DIV cycles.
- frame_done is high in the cycle where the index register changes to 0. It is not asserted on reset release.
- A load value becomes visible on the pins at the first frame boundary at or after the load cycle, plus 1 cycle.
- Blink half-period is BLINK_FRAMES frames.
- First cycle after reset release: dig_sel selects digit 0 showing 0 (0111111).
- Counter widths:
  - prescaler: $clog2(SCAN_DIV).
  - index: max(1, $clog2(NUM_DIGITS)).
  - frame counter: max(1, $clog2(BLINK_FRAMES)).
- All counters wrap without overflow.

## Structure
- Shared package seg7_pkg contains:
  - SEG_BLANK and SEG_DASH constants.
  - the digit pattern constants 0–9.
  - function bcd_to_seg.
- Sub-module seg7_encode is combinational. Inputs are nibble, blank and dp_en; outputs are seg and dp. The driver instantiates it once on the muxed digit.
- The scan and blink counters live in seg7_scan_driver itself.

## Test plan
Use NUM_DIGITS=3, SCAN_DIV=4, BLINK_FRAMES=2, both polarities 0.
- Reset then release, no load → dig_sel steps 001,010,100 every 4 cycles; seg=0111111 throughout; frame_done pulses every 12 cycles.
- load digits_bcd=0x123 mid-frame → old value held until boundary; next frame shows 3,2,1 (1001111, 1011011, 0000110).
- load 0x007 with blank_lz=1 → digits 2 and 1 show 0000000; digit 0 shows 0000111.
  - Same value with blank_lz=0 → digits 2 and 1 show 0111111.
- load 0x0A5 → digit 1 shows dash 1000000.
- blink_en=3'b001 → digit 0 visible 2 frames, blank 2 frames, repeating; other digits are unaffected.
- Assert rst_n=0 mid-digit-1 → outputs off and dig_sel=000 asynchronously; after release, scan restarts at digit 0 with value 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and BCD decode for the 7-segment scan driver.
// Segment vectors are ordered {g,f,e,d,c,b,a}; a '1' lights a segment.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  // Codes 10..15 are not valid BCD and are shown as a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational decode of one digit: nibble to logical segment pattern,
// with blanking forcing all segments and the decimal point off.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp_en,
  output logic [6:0] seg,
  output logic       dp
);

  // Decode the nibble unless the digit is blanked.
  always_comb begin
    seg = blank ? SEG_BLANK : bcd_to_seg(nibble);
    dp  = dp_en & ~blank;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: scans NUM_DIGITS digits over shared
// segment lines, swaps in new values only at frame boundaries, and applies
// leading-zero blanking, per-digit blink and pin polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  // Pin-level "off" values depend on the polarity of the board wiring.
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic                  frame_done_q, frame_done_d;

  logic                  scan_tc;
  logic                  frame_wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp_en;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] cur_sel;
  logic [6:0]            enc_seg;
  logic                  enc_dp;

  // Scan prescaler, digit index, blink timing and the frame-synchronous
  // pending->shadow transfer (a load in the boundary cycle bypasses pending).
  always_comb begin
    presc_d       = presc_q + 1'b1;
    idx_d         = idx_q;
    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    pend_d        = pend_q;
    shadow_d      = shadow_q;
    scan_tc       = (presc_q == PRESC_LAST);
    frame_wrap    = scan_tc && (idx_q == IDX_LAST);
    if (load) pend_d = digits_bcd;
    if (scan_tc) begin
      presc_d = '0;
      idx_d   = frame_wrap ? '0 : idx_q + 1'b1;
    end
    if (frame_wrap) begin
      shadow_d = load ? digits_bcd : pend_q;
      if (frame_q == FRAME_LAST) begin
        frame_d       = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Select the active digit and decide whether it is blanked; the leading-zero
  // run is accumulated from the most significant digit downwards.
  always_comb begin : digit_mux
    logic lz_run;
    logic cur_lz;
    logic cur_blink;
    lz_run    = 1'b1;
    cur_lz    = 1'b0;
    cur_blink = 1'b0;
    cur_nib   = 4'd0;
    cur_dp_en = 1'b0;
    cur_sel   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (shadow_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        cur_nib    = shadow_q[4*i +: 4];
        cur_blink  = blink_en[i];
        cur_dp_en  = dp_en[i];
        cur_lz     = lz_run && (i != 0);
        cur_sel[i] = 1'b1;
      end
    end
    cur_blank = (cur_blink && blink_phase_q) || (blank_lz && cur_lz);
  end

  seg7_encode u_encode (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .dp_en  (cur_dp_en),
    .seg    (enc_seg),
    .dp     (enc_dp)
  );

  // Apply pin polarity to the next registered output values.
  always_comb begin
    seg_d        = enc_seg ^ SEG_OFF;
    dp_d         = enc_dp ^ DP_OFF;
    dig_sel_d    = cur_sel ^ DIG_OFF;
    frame_done_d = frame_wrap;
  end

  // State and output registers; reset puts every pin in its inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
      pend_q        <= '0;
      shadow_q      <= '0;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      dig_sel_q     <= DIG_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
      pend_q        <= pend_d;
      shadow_q      <= shadow_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_sel_q     <= dig_sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule
